keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad (Pmod KYPD style, active-low columns and rows) and reports debounced key presses as 4-bit hex codes. It is the input-side counterpart of the multiplexed 4-digit score display. It time-multiplexes column drive the same way the display multiplexes anodes, but it reads rows back instead of driving segments. Sits between the board keypad pins and the game controller, which consumes `key_valid`/`key_code` for column selection and pop moves.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map, 5-bit {valid, code} key encoding and scan-column state encoding.
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } key_t;

   localparam key_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

   // Indexed [row][col].
   localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   typedef enum logic [1:0] {
      ST_COL0 = 2'd0,
      ST_COL1 = 2'd1,
      ST_COL2 = 2'd2,
      ST_COL3 = 2'd3
   } scan_state_t;

   function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [2:0] add);
      logic [2:0] s;
      s = {1'b0, acc} + add;
      return (s >= 3'd2) ? 2'd2 : s[1:0];
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner and its surroundings.
// slave is the scanner side; master is the keypad/controller side.
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   modport slave (
      input  row,
      output col,
      output key_code,
      output key_valid,
      output key_held
   );

   modport master (
      output row,
      input  col,
      input  key_code,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to RST_VAL so the downstream logic sees idle lines during reset.
module sync_2ff #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column drive, per-scan ghost rejection,
// multi-scan debounce and single-pulse key reporting.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_COL0 | column 0 driven low, settling / sampling
//   ST_COL1 | column 1 driven low, settling / sampling
//   ST_COL2 | column 2 driven low, settling / sampling
//   ST_COL3 | column 3 driven low; its sample ends the scan
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   keypad_scanner_if.slave kp
);

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_SCANS);

   logic [3:0]    w_row_s;
   scan_state_t   r_state;
   scan_state_t   w_state_nxt;
   logic [1:0]    w_col_idx;
   logic          w_tc;
   logic          w_scan_end;

   logic [CW-1:0] r_settle_cnt;
   logic [1:0]    r_hit_cnt;
   logic [3:0]    r_first_code;
   key_t          r_cand;
   logic [SW-1:0] r_stable;
   key_t          r_acc;
   logic [3:0]    r_key_code;
   logic          r_key_valid;

   logic [2:0]    w_col_hits;
   logic [3:0]    w_col_code;
   logic [1:0]    w_hits_tot;
   logic [3:0]    w_code_tot;
   key_t          w_result;
   key_t          w_cand_nxt;
   logic [SW-1:0] w_stable_nxt;
   logic          w_accept;

   sync_2ff #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_row_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (kp.row),
      .o_q   (w_row_s)
   );

   assign w_tc = (r_settle_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_COL0;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_col_idx   = 2'd0;
      w_scan_end  = 1'b0;
      case (r_state)
         ST_COL0: begin
            w_col_idx = 2'd0;
            if (w_tc) w_state_nxt = ST_COL1;
         end
         ST_COL1: begin
            w_col_idx = 2'd1;
            if (w_tc) w_state_nxt = ST_COL2;
         end
         ST_COL2: begin
            w_col_idx = 2'd2;
            if (w_tc) w_state_nxt = ST_COL3;
         end
         ST_COL3: begin
            w_col_idx  = 2'd3;
            w_scan_end = w_tc;
            if (w_tc) w_state_nxt = ST_COL0;
         end
         default: w_state_nxt = ST_COL0;
      endcase
   end

   // Lowest-numbered row wins so the kept code is the first hit in scan order.
   always_comb begin
      w_col_hits = 3'd0;
      w_col_code = 4'h0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!w_row_s[2'(r)]) begin
            w_col_hits = w_col_hits + 3'd1;
            w_col_code = KEY_MAP[2'(r)][w_col_idx];
         end
      end
   end

   always_comb begin
      w_hits_tot = sat_hits(r_hit_cnt, w_col_hits);
      w_code_tot = (r_hit_cnt == 2'd0) ? w_col_code : r_first_code;

      w_result = KEY_NONE;
      if (w_hits_tot == 2'd1) begin
         w_result.valid = 1'b1;
         w_result.code  = w_code_tot;
      end

      if (w_result == r_cand) begin
         w_cand_nxt   = r_cand;
         w_stable_nxt = (r_stable == STABLE_MAX) ? r_stable : r_stable + 1'b1;
      end else begin
         w_cand_nxt   = w_result;
         w_stable_nxt = SW'(1);
      end

      w_accept = (w_stable_nxt == STABLE_MAX) && (w_cand_nxt != r_acc);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_settle_cnt <= SETTLE_LOAD;
         r_hit_cnt    <= 2'd0;
         r_first_code <= 4'h0;
         r_cand       <= KEY_NONE;
         r_stable     <= '0;
         r_acc        <= KEY_NONE;
         r_key_code   <= 4'h0;
         r_key_valid  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_tc) begin
            r_settle_cnt <= SETTLE_LOAD;
            if (w_scan_end) begin
               r_hit_cnt    <= 2'd0;
               r_first_code <= 4'h0;
               r_cand       <= w_cand_nxt;
               r_stable     <= w_stable_nxt;
               if (w_accept) begin
                  r_acc <= w_cand_nxt;
                  // Release keeps the last code; only a new key reports.
                  if (w_cand_nxt.valid) begin
                     r_key_code  <= w_cand_nxt.code;
                     r_key_valid <= 1'b1;
                  end
               end
            end else begin
               r_hit_cnt    <= w_hits_tot;
               r_first_code <= w_code_tot;
            end
         end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
         end
      end
   end

   assign kp.col       = ~(4'b0001 << w_col_idx);
   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;
   assign kp.key_held  = r_acc.valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a keypad matrix model and a
// scan-level reference model (last N scan results agree -> accept).
module tb_keypad_scanner;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;
   localparam int PERIOD = 4 * SETTLE;

   localparam int KMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

   localparam logic [15:0] M1 = 16'h0001;
   localparam logic [15:0] M5 = 16'h0020;
   localparam logic [15:0] M7 = 16'h0100;
   localparam logic [15:0] M9 = 16'h0400;
   localparam logic [15:0] MD = 16'h8000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_scanner_if kp ();

   keypad_scanner #(
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .kp    (kp.slave)
   );

   logic [15:0] pressed = 16'h0;

   always_comb begin
      kp.row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_pulses = 0;
   int q_code[$];
   int q_cyc[$];
   int hist[$];
   int m_acc  = -1;
   int m_code = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_scan(input logic [15:0] mask, input int start);
      int  res;
      bit  same;
      res = -1;
      if ($countones(mask) == 1)
         for (int k = 0; k < 16; k++) if (mask[k]) res = KMAP[k];
      hist.push_back(res);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
         same = 1'b1;
         foreach (hist[i]) if (hist[i] != res) same = 1'b0;
         if (same && res != m_acc) begin
            m_acc = res;
            if (res >= 0) begin
               m_code = res;
               q_code.push_back(res);
               q_cyc.push_back(start + PERIOD);
            end
         end
      end
   endtask

   task automatic model_reset();
      hist.delete();
      q_code.delete();
      q_cyc.delete();
      m_acc  = -1;
      m_code = 0;
   endtask

   // Called #1 after the edge that opens a column-0 window.
   task automatic do_scan(input logic [15:0] mask, input bit check_col);
      int start;
      start = cyc;
      model_scan(mask, start);
      pressed = mask;
      for (int i = 0; i < PERIOD; i++) begin
         if (check_col) begin
            check("idle_col", int'(kp.col), 15 & ~(1 << (i / SETTLE)));
            check("idle_valid", int'(kp.key_valid), 0);
         end
         @(posedge clk);
         #1;
      end
      check("key_held", int'(kp.key_held), (m_acc >= 0) ? 1 : 0);
      check("key_code", int'(kp.key_code), m_code);
   endtask

   bit prev_v = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (kp.key_valid) begin
            n_pulses++;
            check("valid_one_cycle", int'(prev_v), 0);
            if (q_code.size() == 0) begin
               check("unexpected_pulse_code", int'(kp.key_code), -1);
            end else begin
               check("pulse_code", int'(kp.key_code), q_code.pop_front());
               check("pulse_cycle", cyc, q_cyc.pop_front());
            end
         end else if (q_cyc.size() > 0 && cyc > q_cyc[0]) begin
            check("missing_pulse_cycle", cyc, q_cyc[0]);
            void'(q_code.pop_front());
            void'(q_cyc.pop_front());
         end
         prev_v = kp.key_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
      $fatal(1);
   end

   initial begin
      int p0;
      int kind;
      int len;
      int k1;
      int k2;
      logic [15:0] m;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_col", int'(kp.col), 14);
      check("rst_code", int'(kp.key_code), 0);
      check("rst_valid", int'(kp.key_valid), 0);
      check("rst_held", int'(kp.key_held), 0);

      repeat (2) do_scan(16'h0, 1'b1);

      p0 = n_pulses;
      repeat (10) do_scan(M5, 1'b0);
      check("press5_pulses", n_pulses - p0, 1);
      check("press5_code", int'(kp.key_code), 5);

      repeat (4) do_scan(16'h0, 1'b0);
      check("release5_held", int'(kp.key_held), 0);
      check("release5_code", int'(kp.key_code), 5);

      p0 = n_pulses;
      for (int i = 0; i < 10; i++) do_scan((i % 2 == 0) ? M5 : 16'h0, 1'b0);
      check("toggle_pulses", n_pulses - p0, 0);
      check("toggle_held", int'(kp.key_held), 0);

      p0 = n_pulses;
      repeat (10) do_scan(M1 | M9, 1'b0);
      check("ghost_pulses", n_pulses - p0, 0);
      p0 = n_pulses;
      repeat (5) do_scan(M1, 1'b0);
      check("unghost_pulses", n_pulses - p0, 1);
      check("unghost_code", int'(kp.key_code), 1);

      repeat (4) do_scan(16'h0, 1'b0);
      p0 = n_pulses;
      repeat (5) do_scan(MD, 1'b0);
      check("pressD_pulses", n_pulses - p0, 1);
      check("pressD_code", int'(kp.key_code), 13);

      // Reset in the middle of the column-2 window with '7' half debounced.
      repeat (2) do_scan(M7, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("midrst_col", int'(kp.col), 14);
      check("midrst_code", int'(kp.key_code), 0);
      check("midrst_valid", int'(kp.key_valid), 0);
      check("midrst_held", int'(kp.key_held), 0);
      p0 = n_pulses;
      repeat (2) do_scan(M7, 1'b0);
      check("midrst_early_pulses", n_pulses - p0, 0);
      repeat (2) do_scan(M7, 1'b0);
      check("midrst_pulses", n_pulses - p0, 1);

      for (int seg = 0; seg < 30; seg++) begin
         kind = $urandom_range(0, 2);
         k1   = $urandom_range(0, 15);
         k2   = $urandom_range(0, 15);
         m    = 16'h0;
         if (kind >= 1) m[k1] = 1'b1;
         if (kind == 2) m[k2] = 1'b1;
         len = $urandom_range(1, 5);
         repeat (len) do_scan(m, 1'b0);
      end

      repeat (2) do_scan(16'h0, 1'b0);
      check("queue_empty", q_code.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
